// File: rtl/uart_img_pkg.sv
// Shared types and defaults for the UART image loader: FSM state encoding,
// header magic, pixel threshold and pixel address width.
package uart_img_pkg;

  localparam int         ADDR_W_DEF = 16;
  localparam logic [7:0] MAGIC_DEF  = 8'hA5;
  localparam logic [7:0] THRESH_DEF = 8'd128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_W,
    ST_GET_H,
    ST_PIXELS,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic thresh_bit(input logic [7:0] pix, input logic [7:0] thr);
    return (pix >= thr);
  endfunction

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's rx_ready level into a one-cycle byte strobe; byte_q
// presents rx_data in the strobe cycle and holds the last captured byte after.
module rx_byte_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       byte_stb,
  output logic [7:0] byte_q
);

  logic       rdy_q;
  logic [7:0] hold_q;

  // rdy_q resets high so a ready level held through reset is not a new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q  <= 1'b1;
      hold_q <= 8'd0;
    end else begin
      rdy_q <= rx_ready;
      if (byte_stb) hold_q <= rx_data;
    end
  end

  assign byte_stb = rx_ready & ~rdy_q;
  assign byte_q   = byte_stb ? rx_data : hold_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Parses magic/width/height, thresholds pixel bytes into 1-bit memory writes (1 cycle after strobe).
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_frame_loader
  import uart_img_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter logic [7:0] THRESH = THRESH_DEF,
  parameter logic [7:0] MAGIC  = MAGIC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  output logic [7:0]        img_width,
  output logic [7:0]        img_height,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  logic       byte_stb;
  logic [7:0] byte_q;

  rx_byte_strobe u_stb (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .byte_stb (byte_stb),
    .byte_q   (byte_q)
  );

  state_e              state_q;
  logic [15:0]         remaining_q;
  logic [ADDR_W-1:0]   pix_idx_q;
  logic                last_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_wdata_q;
  logic [7:0]          img_width_q;
  logic [7:0]          img_height_q;
  logic                frame_done_q;
  logic                frame_err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= 16'd0;
      pix_idx_q    <= '0;
      last_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 1'b0;
      img_width_q  <= 8'd0;
      img_height_q <= 8'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      mem_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
`ifdef LOADER_CHECKSUM_EN
          xor_q <= 8'd0;
`endif
          if (byte_stb && (byte_q == MAGIC)) state_q <= ST_GET_W;
        end
        ST_GET_W: begin
          if (byte_stb) begin
            img_width_q <= byte_q;
`ifdef LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ byte_q;
`endif
            if (byte_q == 8'd0) begin
              state_q     <= ST_ERR;
              frame_err_q <= 1'b1;
            end else begin
              state_q <= ST_GET_H;
            end
          end
        end
        ST_GET_H: begin
          if (byte_stb) begin
            img_height_q <= byte_q;
`ifdef LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ byte_q;
`endif
            if (byte_q == 8'd0) begin
              state_q     <= ST_ERR;
              frame_err_q <= 1'b1;
            end else begin
              remaining_q <= {8'd0, img_width_q} * {8'd0, byte_q};
              pix_idx_q   <= '0;
              mem_addr_q  <= '0;
              last_q      <= 1'b0;
              state_q     <= ST_PIXELS;
            end
          end
        end
        ST_PIXELS: begin
          // Leave only once the final write is on the bus, so done trails it.
          if (last_q) begin
            last_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            state_q <= ST_CHK;
`else
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
`endif
          end else if (byte_stb) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= thresh_bit(byte_q, THRESH);
            mem_addr_q  <= pix_idx_q;
            pix_idx_q   <= pix_idx_q + ADDR_W'(1);
            remaining_q <= remaining_q - 16'd1;
            last_q      <= (remaining_q == 16'd1);
`ifdef LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ byte_q;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (byte_stb) begin
            if (byte_q == xor_q) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q     <= ST_ERR;
              frame_err_q <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign img_width  = img_width_q;
  assign img_height = img_height_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: vector table, corner sequences and
// randomized frames scored against a stream-level reference parser.
module tb_uart_frame_loader;

  localparam logic [7:0] MAGIC = 8'hA5;
  localparam logic [7:0] THR   = 8'd128;
`ifdef LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 1;
`else
  localparam int DONE_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic        mem_wdata;
  logic [7:0]  img_width;
  logic [7:0]  img_height;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  uart_frame_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .img_width  (img_width),
    .img_height (img_height),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int d;
  } wr_t;

  typedef struct {
    int         len;
    logic [7:0] b [10];
    int         hdr;
    int         nwr;
    logic [7:0] bits;
    int         done;
    int         err;
    int         w;
    int         h;
  } vec_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_rise = -100;
  int  fd_cnt = 0;
  int  fe_cnt = 0;
  int  done_w = 0;
  int  done_h = 0;
  int  done_addr = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  exp_done;
  int  exp_err;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        got_q.push_back('{int'(mem_addr), int'(mem_wdata)});
        chk("we_latency", cyc - last_rise, 1);
      end
      if (frame_done) begin
        fd_cnt++;
        done_w    = int'(img_width);
        done_h    = int'(img_height);
        done_addr = int'(mem_addr);
        chk("done_latency", cyc - last_rise, DONE_LAT);
      end
      if (frame_err) begin
        fe_cnt++;
        chk("err_latency", cyc - last_rise, 1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data   = b;
    rx_ready  = 1'b1;
    last_rise = cyc;
    repeat (4) @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
    repeat (4) @(posedge clk);
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] s[$], input int from);
    logic [7:0] x = 8'd0;
    for (int i = from; i < s.size(); i++) x ^= s[i];
    return x;
  endfunction

  // Reference: walk the byte stream frame by frame using the header rules.
  function automatic void model(input logic [7:0] s[$]);
    int p = 0;
    int w, h, n;
    logic [7:0] x;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    while (p < s.size()) begin
      if (s[p] != MAGIC) begin
        p++;
        continue;
      end
      if (p + 1 >= s.size()) break;
      w = int'(s[p+1]);
      if (w == 0) begin exp_err++; p += 2; continue; end
      if (p + 2 >= s.size()) break;
      h = int'(s[p+2]);
      if (h == 0) begin exp_err++; p += 3; continue; end
      n = w * h;
      x = s[p+1] ^ s[p+2];
      for (int i = 0; i < n; i++) begin
        if (p + 3 + i < s.size()) begin
          exp_q.push_back('{i, (s[p+3+i] >= THR) ? 1 : 0});
          x ^= s[p+3+i];
        end
      end
      p += 3 + n;
`ifdef LOADER_CHECKSUM_EN
      if (p < s.size()) begin
        if (s[p] == x) exp_done++;
        else exp_err++;
        p++;
      end
`else
      if (p <= s.size()) exp_done++;
`endif
    end
  endfunction

  task automatic clear_obs();
    got_q.delete();
    fd_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic compare_model(input string nm);
    chk({nm, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({nm, "_addr"}, got_q[i].addr, exp_q[i].addr);
      chk({nm, "_data"}, got_q[i].d, exp_q[i].d);
    end
    chk({nm, "_done"}, fd_cnt, exp_done);
    chk({nm, "_err"}, fe_cnt, exp_err);
  endtask

  vec_t       vecs [3];
  logic [7:0] s[$];
  logic [7:0] tmp;
  int         fd_snap, fe_snap;

  initial begin
    vecs[0] = '{9, '{8'hA5, 8'h03, 8'h02, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h10, 8'hC8, 8'h00},
                0, 6, 8'h2A, 1, 0, 3, 2};
    vecs[1] = '{6, '{8'h00, 8'h42, 8'hA5, 8'h01, 8'h01, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00},
                2, 1, 8'h01, 1, 0, 1, 1};
    vecs[2] = '{6, '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                2, 1, 8'h00, 1, 1, 1, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_img_width", int'(img_width), 0);
    chk("rst_img_height", int'(img_height), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_err", int'(frame_err), 0);

    // Ready held high through reset release must not count as a byte.
    rx_data  = MAGIC;
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("held_ready_busy", int'(busy), 0);
    rx_ready = 1'b0;
    repeat (6) @(posedge clk);
    clear_obs();
    send_byte(MAGIC);
    chk("rise_after_held_busy", int'(busy), 1);
    s = '{8'h01, 8'h01, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    send_stream(s);
    chk("held_then_frame_done", fd_cnt, 1);
    chk("held_then_frame_nwr", got_q.size(), 1);

    // Vector table.
    for (int v = 0; v < 3; v++) begin
      s.delete();
      for (int i = 0; i < vecs[v].len; i++) s.push_back(vecs[v].b[i]);
`ifdef LOADER_CHECKSUM_EN
      s.push_back(xsum(s, vecs[v].hdr + 1));
`endif
      clear_obs();
      send_stream(s);
      chk($sformatf("v%0d_nwr", v), got_q.size(), vecs[v].nwr);
      for (int i = 0; i < got_q.size() && i < vecs[v].nwr; i++) begin
        tmp = vecs[v].bits;
        chk($sformatf("v%0d_addr%0d", v, i), got_q[i].addr, i);
        chk($sformatf("v%0d_data%0d", v, i), got_q[i].d, int'(tmp[i]));
      end
      chk($sformatf("v%0d_done", v), fd_cnt, vecs[v].done);
      chk($sformatf("v%0d_err", v), fe_cnt, vecs[v].err);
      chk($sformatf("v%0d_width", v), done_w, vecs[v].w);
      chk($sformatf("v%0d_height", v), done_h, vecs[v].h);
      chk($sformatf("v%0d_last_addr", v), done_addr, vecs[v].nwr - 1);
    end

    // Header error: busy must fall right after the error pulse.
    clear_obs();
    send_byte(MAGIC);
    send_byte(8'h00);
    chk("hdr_err_pulse", fe_cnt, 1);
    chk("hdr_err_busy", int'(busy), 0);
    s = '{8'hA5, 8'h07, 8'h00};
    clear_obs();
    send_stream(s);
    chk("zero_height_err", fe_cnt, 1);
    chk("zero_height_nwr", got_q.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    s = '{8'hA5, 8'h02, 8'h01, 8'h10, 8'h20, 8'h33};
    clear_obs();
    send_stream(s);
    chk("chk_good_done", fd_cnt, 1);
    chk("chk_good_err", fe_cnt, 0);
    s = '{8'hA5, 8'h02, 8'h01, 8'h10, 8'h20, 8'h34};
    clear_obs();
    send_stream(s);
    chk("chk_bad_done", fd_cnt, 0);
    chk("chk_bad_err", fe_cnt, 1);
`endif

    // Randomized frames with garbage, header errors and (optionally) bad checksums.
    s.delete();
    for (int f = 0; f < 15; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        tmp = 8'($urandom_range(0, 255));
        s.push_back((tmp == MAGIC) ? 8'h5A : tmp);
      end
      s.push_back(MAGIC);
      if ($urandom_range(0, 5) == 0) begin
        s.push_back(8'h00);
        continue;
      end
      begin
        int w = $urandom_range(1, 5);
        int h = $urandom_range(1, 5);
        logic [7:0] x;
        s.push_back(8'(w));
        s.push_back(8'(h));
        x = 8'(w) ^ 8'(h);
        for (int i = 0; i < w * h; i++) begin
          tmp = 8'($urandom_range(0, 255));
          s.push_back(tmp);
          x ^= tmp;
        end
`ifdef LOADER_CHECKSUM_EN
        s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
`else
        if (x == 8'hFF) s.push_back(8'h00);
`endif
      end
    end
    model(s);
    clear_obs();
    send_stream(s);
    compare_model("rand");

    // Reset mid-frame after 3 of 6 pixels.
    s = '{8'hA5, 8'h03, 8'h02, 8'h00, 8'h80, 8'h7F};
    clear_obs();
    send_stream(s);
    chk("mid_nwr", got_q.size(), 3);
    chk("mid_addr_before", int'(mem_addr), 2);
    chk("mid_busy_before", int'(busy), 1);
    fd_snap = fd_cnt;
    fe_snap = fe_cnt;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_mem_addr", int'(mem_addr), 0);
    chk("mid_rst_img_width", int'(img_width), 0);
    chk("mid_rst_img_height", int'(img_height), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mem_we", int'(mem_we), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    chk("mid_rst_no_done", fd_cnt, fd_snap);
    chk("mid_rst_no_err", fe_cnt, fe_snap);
    chk("mid_rst_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Downstream consumer of the UART receiver. Turns the receiver's byte stream into a binary image in pixel memory for the chain-code encoder. Parses a 3-byte header (magic, width, height), then thresholds each following pixel byte to 1 bit and writes it to a linear address. Signals completion or error to the encoder control.

Parameters:
ADDR_W, 16, pixel memory address width; must hold 255*255-1
THRESH, 8'd128, pixel byte >= THRESH writes 1, otherwise writes 0
MAGIC, 8'hA5, required first header byte

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rx_data  input  8  byte from UART receiver; valid only in the cycle rx_ready rises
rx_ready  input  1  level from receiver; rises when a byte completes, falls on next start bit
mem_we  output  1  pixel memory write strobe, one cycle per pixel
mem_addr  output  ADDR_W  pixel write address, row-major, 0-based
mem_wdata  output  1  thresholded pixel
img_width  output  8  latched width, valid from GET_H onward
img_height  output  8  latched height, valid from PIXELS onward
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse after last pixel write (after checksum if enabled)
frame_err  output  1  one-cycle pulse on header or checksum error

Behaviour:
- Reset (rst low, async): state IDLE; mem_we, mem_addr, mem_wdata, img_width, img_height, frame_done, frame_err all 0; edge register rdy_q cleared to 1, so a ready held high through reset is not counted as a byte.
- Byte strobe: byte_stb = rx_ready & ~rdy_q, where rdy_q is rx_ready delayed one cycle. rx_data is captured in the byte_stb cycle only.
- IDLE: on byte_stb, go to GET_W if the byte equals MAGIC; otherwise stay in IDLE silently (resync).
- GET_W: on byte_stb, latch img_width.
  - byte==0: go to ERR.
  - otherwise: go to GET_H.
- GET_H: on byte_stb, latch img_height.
  - byte==0: go to ERR.
  - otherwise: load remaining = width*height (16-bit product), set mem_addr=0, go to PIXELS.
- PIXELS: on each byte_stb, registered outputs update the next cycle: mem_we=1, mem_wdata=(byte>=THRESH), mem_addr=current pixel index. Address increments after each write. Remaining count decrements. On the last pixel's write cycle, go to DONE (or CHK if enabled).
- DONE: assert frame_done for exactly one cycle, then go to IDLE. mem_addr holds the last address; img_width and img_height hold their values.
- ERR: assert frame_err for exactly one cycle, then go to IDLE.
- Latency: byte_stb to mem_we is exactly 1 cycle. The last byte_stb to frame_done is 2 cycles.
- A byte_stb arriving during DONE or ERR is dropped; the protocol guarantees at least 10 clocks between bytes.
- Maximum frame is 255x255 = 65025 pixels; no wrap. Bytes beyond W*H are treated as new IDLE traffic.
- rst asserted mid-frame: immediate return to IDLE. Partially written memory is not cleared and no frame_err is issued.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the last pixel, the FSM enters CHK and waits for one more byte equal to the XOR of width, height and all raw pixel bytes. A match goes to DONE; a mismatch goes to ERR. The running XOR is reset in IDLE.
- Undefined: no CHK state and no XOR register; PIXELS goes directly to DONE.

Decomposition:
- Shared package uart_img_pkg holds:
  - state enum (IDLE, GET_W, GET_H, PIXELS, CHK, DONE, ERR)
  - MAGIC and THRESH default constants
  - ADDR_W default
- One natural sub-module: rx_byte_strobe, containing the rdy_q register, rising-edge detect and rx_data capture register. It outputs byte_stb and byte_q.

Test Plan:
- Stream A5,03,02 then pixels 00,80,7F,FF,10,C8 -> six mem_we pulses at addr 0..5 with wdata 0,1,0,1,0,1; img_width=3, img_height=2; one frame_done.
- Stream 00,42,A5,01,01,90 -> leading bytes ignored; one write at addr 0 with wdata 1; frame_done.
- Stream A5,00 -> frame_err pulse; busy falls; the following A5,01,01,00 completes normally.
- Hold rx_ready high through reset release -> no byte_stb and state stays IDLE; the next genuine rise is captured.
- Assert rst after 3 of 6 pixels -> outputs return to reset values immediately; no frame_done or frame_err.
- With LOADER_CHECKSUM_EN: A5,02,01,10,20 then checksum 33 -> frame_done; checksum 34 -> frame_err.
